// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, status bit indices and limits for the UART receive engine
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BRKWAIT
  } rx_state_t;

  localparam int STAT_PERR = 0;
  localparam int STAT_FERR = 1;
  localparam int STAT_BRK  = 2;

  localparam int MIN_DIV = 4;

  // Places the three error flags at their status-word positions.
  function automatic logic [2:0] pack_status(input logic brk, input logic ferr, input logic perr);
    logic [2:0] s;
    s            = '0;
    s[STAT_BRK]  = brk;
    s[STAT_FERR] = ferr;
    s[STAT_PERR] = perr;
    return s;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous show-ahead FIFO holding received words plus status
module uart_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_pop;
  logic             do_push;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Word storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_fifo_engine.sv
// rtl/uart_rx_fifo_engine.sv - UART receiver with configurable frame, break detect and status FIFO (option: UART_RX_MAJORITY_EN)
module uart_rx_fifo_engine
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIV_W       = 19,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [3:0]                    cfg_len,
  input  logic                          cfg_pen,
  input  logic                          cfg_odd,
  input  logic                          cfg_stop2,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic [2:0]                    rd_status,
  output logic                          rx_ready,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rx_busy
);

  localparam int FW = DATA_W + 3;
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  rx_state_t              state_q, state_d;
  logic [DIV_W-1:0]       bt_cnt_q, bt_cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   pbit_q, pbit_d;
  logic                   stop1_q, stop1_d;
  logic                   push_q, push_d;
  logic [FW-1:0]          push_word_q, push_word_d;
  logic                   ovf_q;

  logic [DIV_W-1:0]       div_in;
  logic [DIV_W-1:0]       half;
  logic [3:0]             len_eff;
  logic                   bit_val;
  logic                   start_tick;
  logic                   bit_tick;
  logic [DIV_W-1:0]       bt_restart;
  logic                   perr_w;
  logic                   brk_w;

  logic [FW-1:0]          head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop_eff;

  // Bring the asynchronous pin into the clock domain; idles high.
  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rxs = sync_q[SYNC_STAGES-1];

  assign div_in = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;
  assign half   = div_q >> 1;

  always_comb begin
    len_eff = cfg_len;
    if (cfg_len < 4'd5)               len_eff = 4'd5;
    else if (cfg_len > 4'(DATA_W))    len_eff = 4'(DATA_W);
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Keep the two previous synchronised samples for the 2-of-3 vote.
  always_ff @(posedge clk) begin
    if (!rst) hist_q <= 2'b11;
    else      hist_q <= {hist_q[0], rxs};
  end

  // Vote is decided one cycle after the nominal sample; the counter is
  // restarted at 1 so later bit targets stay where the single-sample build has them.
  assign bit_val    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
  assign start_tick = (bt_cnt_q == half + DIV_ONE);
  assign bit_tick   = (bt_cnt_q == '0);
  assign bt_restart = DIV_ONE;
`else
  assign bit_val    = rxs;
  assign start_tick = (bt_cnt_q == half);
  assign bit_tick   = (bt_cnt_q == div_q - DIV_ONE);
  assign bt_restart = '0;
`endif

  assign perr_w = cfg_pen & (^data_q ^ pbit_q ^ cfg_odd);
  assign brk_w  = (data_q == '0) && !(cfg_pen && pbit_q) && !bit_val;

  // Frame FSM next state, bit timing, data capture and push word assembly.
  always_comb begin
    state_d     = state_q;
    bt_cnt_d    = (bt_cnt_q == div_q - DIV_ONE) ? '0 : bt_cnt_q + DIV_ONE;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    data_d      = data_q;
    pbit_d      = pbit_q;
    stop1_d     = stop1_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    case (state_q)
      IDLE: begin
        bt_cnt_d = '0;
        if (!rxs) begin
          state_d   = START;
          div_d     = div_in;
          bit_cnt_d = '0;
          data_d    = '0;
          pbit_d    = 1'b0;
        end
      end
      START: begin
        if (start_tick) begin
          state_d  = bit_val ? IDLE : DATA;
          bt_cnt_d = bt_restart;
        end
      end
      DATA: begin
        if (bit_tick) begin
          data_d = data_q | (DATA_W'(bit_val) << bit_cnt_q);
          if (bit_cnt_q == len_eff - 4'd1) state_d = cfg_pen ? PARITY : STOP1;
          else                             bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          pbit_d  = bit_val;
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (bit_tick) begin
          if (brk_w) begin
            push_d      = 1'b1;
            push_word_d = {pack_status(1'b1, 1'b1, perr_w), data_q};
            state_d     = BRKWAIT;
          end else if (cfg_stop2) begin
            stop1_d = bit_val;
            state_d = STOP2;
          end else begin
            push_d      = 1'b1;
            push_word_d = {pack_status(1'b0, ~bit_val, perr_w), data_q};
            state_d     = IDLE;
          end
        end
      end
      STOP2: begin
        if (bit_tick) begin
          push_d      = 1'b1;
          push_word_d = {pack_status(1'b0, ~(stop1_q & bit_val), perr_w), data_q};
          state_d     = IDLE;
        end
      end
      BRKWAIT: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bt_cnt_q    <= '0;
      div_q       <= DIV_W'(MIN_DIV);
      bit_cnt_q   <= '0;
      data_q      <= '0;
      pbit_q      <= 1'b0;
      stop1_q     <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      state_q     <= state_d;
      bt_cnt_q    <= bt_cnt_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      pbit_q      <= pbit_d;
      stop1_q     <= stop1_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
    end
  end

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (push_q),
    .wdata_i (push_word_q),
    .pop_i   (rd_en),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign pop_eff = rd_en && !fifo_empty;

  // Sticky overflow: set on a dropped word, cleared by a pop that drops nothing.
  always_ff @(posedge clk) begin
    if (!rst)                                  ovf_q <= 1'b0;
    else if (push_q && fifo_full && !pop_eff)  ovf_q <= 1'b1;
    else if (pop_eff)                          ovf_q <= 1'b0;
  end

  assign ovf       = ovf_q;
  assign rx_ready  = !fifo_empty;
  assign rx_busy   = (state_q != IDLE);
  assign rd_data   = fifo_empty ? '0 : head[DATA_W-1:0];
  assign rd_status = fifo_empty ? '0 : head[FW-1:DATA_W];

endmodule

// File: tb/tb_uart_rx_fifo_engine.sv
// tb/tb_uart_rx_fifo_engine.sv - scoreboard bench for uart_rx_fifo_engine
module tb_uart_rx_fifo_engine;

  localparam int DW    = 9;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [18:0] baud_div;
  logic [3:0]  cfg_len;
  logic        cfg_pen;
  logic        cfg_odd;
  logic        cfg_stop2;
  logic        rd_en;
  logic [DW-1:0] rd_data;
  logic [2:0]  rd_status;
  logic        rx_ready;
  logic        ovf;
  logic [4:0]  fifo_level;
  logic        rx_busy;

  int n_cmp = 0;
  int n_err = 0;
  int bit_clks = 10;
  logic [11:0] exp_q[$];
  logic [11:0] e;

  uart_rx_fifo_engine #(
    .DATA_W      (DW),
    .DIV_W       (19),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud_div   (baud_div),
    .cfg_len    (cfg_len),
    .cfg_pen    (cfg_pen),
    .cfg_odd    (cfg_odd),
    .cfg_stop2  (cfg_stop2),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_status  (rd_status),
    .rx_ready   (rx_ready),
    .ovf        (ovf),
    .fifo_level (fifo_level),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    tick(bit_clks);
  endtask

  task automatic send_frame(input logic [8:0] d, input int len, input logic pen, input logic pbit,
                            input logic s1, input logic two, input logic s2);
    drive_bit(1'b0);
    for (int i = 0; i < len; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(s1);
    if (two) drive_bit(s2);
    rx = 1'b1;
    tick(2 * bit_clks);
  endtask

  task automatic expect_word(input logic [2:0] st, input logic [8:0] d);
    exp_q.push_back({st, d});
  endtask

  task automatic pop_one(input string tag);
    logic [11:0] w;
    w = exp_q.pop_front();
    check_eq({tag, ".rdy"},  rx_ready,  1);
    check_eq({tag, ".data"}, rd_data,   w[8:0]);
    check_eq({tag, ".stat"}, rd_status, w[11:9]);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_one(tag);
    check_eq({tag, ".empty"}, rx_ready, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".rdy"},   rx_ready,   0);
    check_eq({tag, ".ovf"},   ovf,        0);
    check_eq({tag, ".lvl"},   fifo_level, 0);
    check_eq({tag, ".busy"},  rx_busy,    0);
    check_eq({tag, ".data"},  rd_data,    0);
    check_eq({tag, ".stat"},  rd_status,  0);
  endtask

  initial begin
    rst = 1'b0; rx = 1'b1; baud_div = 19'd10; cfg_len = 4'd8;
    cfg_pen = 1'b0; cfg_odd = 1'b0; cfg_stop2 = 1'b0; rd_en = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    tick(2);

    // 8N1 single word
    send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_word(3'b000, 9'h0A5);
    check_eq("t1.lvl", fifo_level, 1);
    drain("t1");

    // 7-bit parity: even with bad parity bit, then odd with good parity bit
    cfg_len = 4'd7; cfg_pen = 1'b1; cfg_odd = 1'b0;
    send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_word(3'b001, 9'h041);
    cfg_odd = 1'b1;
    send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_word(3'b000, 9'h041);
    drain("t2");
    cfg_pen = 1'b0; cfg_odd = 1'b0; cfg_len = 4'd8;

    // glitch shorter than half a bit is rejected
    rx = 1'b0;
    tick(3);
    check_eq("t3.busy_hi", rx_busy, 1);
    rx = 1'b1;
    tick(20);
    check_eq("t3.busy_lo", rx_busy, 0);
    check_eq("t3.lvl", fifo_level, 0);

    // length clamps and minimum divisor
    cfg_len = 4'd3;
    send_frame(9'h015, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_word(3'b000, 9'h015);
    cfg_len = 4'd15;
    send_frame(9'h155, 9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_word(3'b000, 9'h155);
    cfg_len = 4'd8; baud_div = 19'd2; bit_clks = 4;
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_word(3'b000, 9'h05A);
    drain("t4");
    baud_div = 19'd10; bit_clks = 10;

    // overflow: 17 frames into 16 entries
    for (int i = 0; i < 17; i++) begin
      send_frame(9'(i), 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i < DEPTH) expect_word(3'b000, 9'(i));
    end
    check_eq("t5.lvl", fifo_level, 16);
    check_eq("t5.ovf", ovf, 1);
    pop_one("t5.first");
    check_eq("t5.ovf_clr", ovf, 0);
    drain("t5");

    // break: 20 bit times low, then a normal frame
    rx = 1'b0;
    tick(20 * bit_clks);
    rx = 1'b1;
    tick(2 * bit_clks);
    expect_word(3'b110, 9'h000);
    check_eq("t6.busy", rx_busy, 0);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_word(3'b000, 9'h03C);
    check_eq("t6.lvl", fifo_level, 2);
    drain("t6");

    // two stop bits, 9 data bits
    cfg_stop2 = 1'b1; cfg_len = 4'd9;
    send_frame(9'h1FF, 9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    expect_word(3'b010, 9'h1FF);
    send_frame(9'h0AA, 9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_word(3'b000, 9'h0AA);
    drain("t7");

    // reset mid-frame with a stored word: everything cleared, nothing pushed
    cfg_stop2 = 1'b0; cfg_len = 4'd8;
    send_frame(9'h033, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t8.pre_lvl", fifo_level, 1);
    rx = 1'b0;
    tick(25);
    check_eq("t8.pre_busy", rx_busy, 1);
    rst = 1'b0; rx = 1'b1;
    tick(1);
    check_reset_outputs("t8.rst");
    rst = 1'b1;
    tick(300);
    check_eq("t8.lvl", fifo_level, 0);
    check_eq("t8.busy", rx_busy, 0);
    check_eq("t8.q", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
